// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with registered, one-hot grant and level-held requests.
// Define ARB_TIMEOUT_EN to force rotation after TMAX consecutive grant cycles when others wait.
module rr_arbiter4
`ifdef ARB_TIMEOUT_EN
#(
    parameter int TMAX = 8
)
`endif
(
    input  logic       CLK,
    input  logic       RSTN,
    input  logic [3:0] REQ,
    output logic [3:0] GNT,
    output logic       VALID,
    output logic [1:0] ID
);

    localparam logic MODE_IDLE  = 1'b0;
    localparam logic MODE_GRANT = 1'b1;

    logic       r_mode;
    logic [1:0] r_ptr;
    logic [3:0] r_gnt;
    logic [1:0] r_id;

    logic [1:0] w_next_idx;
    logic [1:0] w_base;
    logic [3:0] w_rot;
    logic [1:0] w_off;
    logic [1:0] w_win;
    logic       w_found;
    logic       w_timeout;
    logic       w_release;
    logic       w_load;

    assign w_next_idx = r_id + 2'd1;
    // A releasing owner hands over starting from its successor; from idle the pointer decides.
    assign w_base     = (r_mode == MODE_GRANT) ? w_next_idx : r_ptr;

    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_rot = REQ;
        case (w_base)
            2'd1:    w_rot = {REQ[0],   REQ[3:1]};
            2'd2:    w_rot = {REQ[1:0], REQ[3:2]};
            2'd3:    w_rot = {REQ[2:0], REQ[3]};
            default: w_rot = REQ;
        endcase
    end

    always_comb begin
        w_off = 2'd0;
        if (w_rot[0])      w_off = 2'd0;
        else if (w_rot[1]) w_off = 2'd1;
        else if (w_rot[2]) w_off = 2'd2;
        else if (w_rot[3]) w_off = 2'd3;
    end

    assign w_found   = |w_rot;
    assign w_win     = w_base + w_off;
    assign w_release = (r_mode == MODE_GRANT) && (!REQ[r_id] || w_timeout);
    assign w_load    = w_found && ((r_mode == MODE_IDLE) || w_release);

`ifdef ARB_TIMEOUT_EN
    logic [3:0] r_hcnt;

    // The owner is pre-empted only when it has held TMAX cycles and someone else is waiting.
    assign w_timeout = (r_hcnt >= 4'(TMAX - 1)) && |(REQ & ~r_gnt);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_hcnt <= 4'd0;
        end else if (w_load) begin
            r_hcnt <= 4'd0;
        end else if ((r_mode == MODE_GRANT) && (r_hcnt < 4'(TMAX))) begin
            r_hcnt <= r_hcnt + 4'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_mode <= MODE_IDLE;
            r_ptr  <= 2'd0;
            r_gnt  <= 4'b0000;
            r_id   <= 2'd0;
        end else begin
            if (w_release) begin
                r_ptr <= w_next_idx;
            end
            if (w_load) begin
                r_mode <= MODE_GRANT;
                r_gnt  <= 4'b0001 << w_win;
                r_id   <= w_win;
            end else if (w_release) begin
                r_mode <= MODE_IDLE;
                r_gnt  <= 4'b0000;
                r_id   <= 2'd0;
            end
        end
    end

    assign GNT   = r_gnt;
    assign VALID = r_mode;
    assign ID    = r_id;

endmodule

// File: doc/rr_arbiter4.md
RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 Parameter: TMAX, default 8, maximum consecutive grant cycles before forced rotation; legal range 2..15; used only when ARB_TIMEOUT_EN is defined.
REQ-002 Port: CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: RSTN  input  1  reset, asynchronous, active-low.
REQ-004 Port: REQ  input  4  request vector; bit j = requester j; level-sensitive; held high for as long as the grant is wanted.
REQ-005 Port: GNT  output  4  registered grant vector; one-hot or all-zero.
REQ-006 Port: VALID  output  1  registered; high iff GNT is nonzero.
REQ-007 Port: ID  output  2  registered binary index of the granted requester; 0 when VALID=0.

Function
REQ-008 Internal state: mode IDLE/GRANT; 2-bit priority pointer PTR; 4-bit hold counter HCNT, present only with ARB_TIMEOUT_EN.
REQ-009 Winner search: the first j with REQ[j]=1, scanning PTR, PTR+1, PTR+2, PTR+3, all modulo 4.
REQ-010 IDLE with REQ=0000: stays in IDLE; GNT=0000.
REQ-011 IDLE with any REQ bit set: at the next edge, GNT = one-hot winner, ID = its index, VALID=1, mode becomes GRANT; latency from REQ to GNT is 1 cycle.
REQ-012 GRANT on index i with REQ[i]=1: GNT, ID and PTR hold; other requests are ignored.
REQ-013 GRANT on index i with REQ[i]=0 at an edge: PTR <= i+1 mod 4 at that edge.
REQ-014 Handover in the same edge as REQ-013: if another request is present, the winner is searched from i+1 and granted with no idle cycle; otherwise GNT=0000 and mode becomes IDLE.
REQ-015 GNT[j] is asserted only if REQ[j]=1 at the edge that grants it; a request dropped before being granted is discarded with no memory.
REQ-016 GNT has at most one bit set in every cycle, including handover and timeout cycles.
REQ-017 Pointer wrap: after a release by index 3, PTR=0.

Reset
REQ-018 RSTN=0 immediately forces GNT=0000, VALID=0, ID=0, PTR=0, HCNT=0 and mode IDLE, independent of CLK.
REQ-019 A reset asserted mid-grant discards the grant and prior priority; after release, arbitration restarts from PTR=0.
REQ-020 The first grant is possible at the first rising edge at which RSTN=1.

Configuration
REQ-021 Macro: ARB_TIMEOUT_EN.
REQ-022 With ARB_TIMEOUT_EN defined:
- HCNT clears on every new grant and increments each cycle GNT is held.
- After GNT has been high for TMAX consecutive cycles, if any other REQ bit is set, the next edge rotates the grant as in REQ-013/REQ-014 even though REQ[i]=1.
- If no other request is pending, the grant holds and HCNT saturates at TMAX.
REQ-023 Without ARB_TIMEOUT_EN: HCNT and TMAX have no effect and are not implemented; a grant holds until REQ[i] drops.

Verification
REQ-024 Reset: RSTN=0 mid-grant with GNT=0100 -> GNT=0000, VALID=0, ID=0 before the next edge; release with REQ=0110 -> first edge gives GNT=0010, ID=1.
REQ-025 Single requester: REQ=0001 raised before edge n -> GNT=0001, VALID=1, ID=0 after edge n; REQ dropped before edge n+3 -> GNT=0000 after edge n+3.
REQ-026 Fairness: REQ=1111; each granted requester drops REQ for one edge after 2 grant cycles, then re-raises -> grant order 0,1,2,3,0, with zero-idle handovers and GNT never multi-hot.
REQ-027 Wrap and skip: requester 3 releases while REQ=0101 -> next GNT=0001, ID=0; requester 0 then releases -> GNT=0100, ID=2.
REQ-028 Timeout (macro defined, TMAX=8): REQ=0011 held continuously -> GNT=0001 for exactly 8 cycles, then 0010 for 8 cycles, then 0001; the same stimulus without the macro -> GNT=0001 indefinitely.
REQ-029 Timeout with no contender (macro defined): REQ=0100 held for 20 cycles -> GNT=0100 throughout with no glitch at cycle 8.
